// File: rtl/pic_fetch_unit.sv
// Instruction fetch stage: PC, MAR, return stack and IR, handing one instruction at a time to execute.
// Fetch is 3 cycles (ADDR, ROM, LOAD) plus HOLD; the stage stalls in HOLD while ex_ready is low.
module pic_fetch_unit #(
    parameter int PC_W        = 11,
    parameter int IW          = 14,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] rom_addr,
    input  logic [IW-1:0]   rom_data,
    output logic [IW-1:0]   ir_q,
    output logic            ir_valid,
    input  logic            ex_ready,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic            skip,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc_q,
    output logic            stack_ovf,
    output logic            stack_unf
);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0]  PC_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(STACK_DEPTH);

    typedef enum logic [1:0] {S_ADDR, S_ROM, S_LOAD, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   mar_q, mar_d;
    logic [IW-1:0]     ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [PC_W-1:0]   stack_d [STACK_DEPTH];
    logic [PTR_W-1:0]  top_idx;
    logic              consume;

    assign rom_addr  = mar_q;
    assign ir_valid  = ir_valid_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
    assign consume   = ir_valid_q && ex_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        stack_d    = stack_q;
        top_idx    = sp_q - PTR_ONE;
        case (state_q)
            S_ADDR: begin
                mar_d   = pc_q;
                pc_d    = pc_q + PC_ONE;
                state_d = S_ROM;
            end
            S_ROM: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ir_d       = rom_data;
                ir_valid_d = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (consume) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_ADDR;
                    // pc_q already points past the consumed instruction, so it is the return address
                    if (ret) begin
                        if (cnt_q != '0) begin
                            pc_d  = stack_q[top_idx];
                            sp_d  = top_idx;
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            pc_d  = '0;
                            unf_d = 1'b1;
                        end
                    end else if (call) begin
                        stack_d[sp_q] = pc_q;
                        sp_d          = sp_q + PTR_ONE;
                        if (cnt_q == CNT_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        pc_d = jump_addr;
                    end else if (jump) begin
                        pc_d = jump_addr;
                    end else if (skip) begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ADDR;
            pc_q       <= '0;
            mar_q      <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            stack_q    <= stack_d;
        end
    end
endmodule

// File: tb/tb_pic_fetch_unit.sv
// Bench for pic_fetch_unit: directed table, hand sequences and random redirects against a queue-based model.
module tb_pic_fetch_unit;
    localparam int PC_W  = 11;
    localparam int IW    = 14;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] rom_addr;
    logic [IW-1:0]   rom_data = '0;
    logic [IW-1:0]   ir_q;
    logic            ir_valid;
    logic            ex_ready = 1'b0;
    logic            jump = 1'b0, call = 1'b0, ret = 1'b0, skip = 1'b0;
    logic [PC_W-1:0] jump_addr = '0;
    logic [PC_W-1:0] pc_q;
    logic            stack_ovf, stack_unf;

    pic_fetch_unit #(.PC_W(PC_W), .IW(IW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir_q(ir_q), .ir_valid(ir_valid), .ex_ready(ex_ready),
        .jump(jump), .call(call), .ret(ret), .skip(skip), .jump_addr(jump_addr),
        .pc_q(pc_q), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom_mem [0:2047];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int checks = 0;
    int failures = 0;

    // Reference model: address of the next instruction fetched, plus the return stack as a queue.
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_stk [$];
    logic            m_ovf, m_unf;

    typedef struct {
        logic [3:0]      st;   // {jump, call, ret, skip}
        logic [PC_W-1:0] a;
        logic [PC_W-1:0] fetch;
        logic [PC_W-1:0] pc;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Waits for ir_valid with ex_ready low, toggling junk strobes that must be ignored.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ir_valid) begin
                ok = 1'b1;
                break;
            end
            ex_ready  = 1'b0;
            jump      = 1'($urandom);
            call      = 1'($urandom);
            ret       = 1'($urandom);
            skip      = 1'($urandom);
            jump_addr = 11'($urandom);
            @(negedge clk);
        end
        jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: ir_valid stayed 0 for 40 cycles, expected 1");
        end
    endtask

    task automatic issue(input logic j, input logic c, input logic r, input logic s,
                         input logic [PC_W-1:0] a,
                         output logic [IW-1:0] got_ir, output logic [PC_W-1:0] got_pc);
        bit ok;
        logic [PC_W-1:0] f, nxt;
        wait_valid(ok);
        f = m_pc;
        got_ir = ir_q;
        chk("ir", 32'(ir_q), 32'(rom_mem[f]));
        ex_ready = 1'b1; jump = j; call = c; ret = r; skip = s; jump_addr = a;
        @(negedge clk);
        ex_ready = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
        nxt = f + 11'd1;
        if (r) begin
            if (m_stk.size() > 0) nxt = m_stk.pop_back();
            else begin
                nxt = '0;
                m_unf = 1'b1;
            end
        end else if (c) begin
            if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_stk.push_back(nxt);
            nxt = a;
        end else if (j) begin
            nxt = a;
        end else if (s) begin
            nxt = nxt + 11'd1;
        end
        m_pc = nxt;
        got_pc = pc_q;
        chk("pc", 32'(pc_q), 32'(m_pc));
        chk("ir_valid_drop", 32'(ir_valid), 32'd0);
        chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
        chk("stack_unf", 32'(stack_unf), 32'(m_unf));
    endtask

    task automatic release_and_check_first();
        int n;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (ir_valid) break;
        end
        chk("first_valid_latency", 32'(n), 32'd3);
        chk("first_ir", 32'(ir_q), 32'(rom_mem[0]));
    endtask

    initial begin
        logic [IW-1:0]   gir;
        logic [PC_W-1:0] gpc;
        logic [PC_W-1:0] ra [9];
        int nvalid;
        bit ok;

        for (int i = 0; i < 2048; i++) rom_mem[i] = 14'h3000 + 14'(i);
        model_reset();

        tbl[0]  = '{4'b0000, 11'h000, 11'h003, 11'h004};
        tbl[1]  = '{4'b0000, 11'h000, 11'h004, 11'h005};
        tbl[2]  = '{4'b1000, 11'h123, 11'h005, 11'h123};
        tbl[3]  = '{4'b1000, 11'h010, 11'h123, 11'h010};
        tbl[4]  = '{4'b0100, 11'h200, 11'h010, 11'h200};
        tbl[5]  = '{4'b0010, 11'h000, 11'h200, 11'h011};
        tbl[6]  = '{4'b1000, 11'h7FE, 11'h011, 11'h7FE};
        tbl[7]  = '{4'b0001, 11'h000, 11'h7FE, 11'h000};
        tbl[8]  = '{4'b0000, 11'h000, 11'h000, 11'h001};
        tbl[9]  = '{4'b1101, 11'h050, 11'h001, 11'h050};
        tbl[10] = '{4'b1110, 11'h300, 11'h050, 11'h002};
        tbl[11] = '{4'b0000, 11'h000, 11'h002, 11'h003};
        tbl[12] = '{4'b1001, 11'h7FF, 11'h003, 11'h7FF};
        tbl[13] = '{4'b0000, 11'h000, 11'h7FF, 11'h000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc_q), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_ir", 32'(ir_q), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ovf", 32'(stack_ovf), 32'd0);
        chk("rst_unf", 32'(stack_unf), 32'd0);

        // Streaming with ex_ready held high: pulses at cycles 3, 7, 11
        rst = 1'b0;
        ex_ready = 1'b1;
        nvalid = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ir_valid) begin
                chk("valid_slot", 32'(n), 32'(3 + 4 * nvalid));
                chk("stream_ir", 32'(ir_q), 32'(rom_mem[nvalid]));
                nvalid++;
            end
        end
        ex_ready = 1'b0;
        chk("stream_count", 32'(nvalid), 32'd3);
        chk("stream_pc", 32'(pc_q), 32'd3);
        m_pc = 11'd3;

        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].st[3], tbl[i].st[2], tbl[i].st[1], tbl[i].st[0], tbl[i].a, gir, gpc);
            chk($sformatf("tbl%0d_ir", i), 32'(gir), 32'(rom_mem[tbl[i].fetch]));
            chk($sformatf("tbl%0d_pc", i), 32'(gpc), 32'(tbl[i].pc));
        end
        chk("tbl_stack_empty_ovf", 32'(stack_ovf), 32'd0);

        // Stall in HOLD with strobes active but no consume
        wait_valid(ok);
        for (int i = 0; i < 10; i++) begin
            jump = 1'b1; call = 1'b1; ret = 1'b1; skip = 1'b1; jump_addr = 11'h555;
            @(negedge clk);
            chk("hold_valid", 32'(ir_valid), 32'd1);
            chk("hold_ir", 32'(ir_q), 32'(rom_mem[m_pc]));
            chk("hold_pc", 32'(pc_q), 32'(m_pc + 11'd1));
        end
        jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 11'h0, gir, gpc);

        // Nine nested calls overflow the 8-deep stack; the oldest return address is lost
        ra[0] = m_pc + 11'd1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) ra[k] = 11'h100 + 11'(16 * (k - 1)) + 11'd1;
            issue(1'b0, 1'b1, 1'b0, 1'b0, 11'h100 + 11'(16 * k), gir, gpc);
            chk("call_ovf", 32'(stack_ovf), 32'(k == 8));
        end
        for (int r = 0; r < 8; r++) begin
            issue(1'b0, 1'b0, 1'b1, 1'b0, 11'h0, gir, gpc);
            chk($sformatf("ret%0d_pc", r), 32'(gpc), 32'(ra[8 - r]));
            chk("ret_unf", 32'(stack_unf), 32'd0);
        end
        issue(1'b0, 1'b0, 1'b1, 1'b0, 11'h0, gir, gpc);
        chk("underflow_pc", 32'(gpc), 32'd0);
        chk("underflow_flag", 32'(stack_unf), 32'd1);

        // Random redirects
        for (int i = 0; i < 80; i++) begin
            int sel;
            logic [3:0] st;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: st = 4'b1000;
                2:    st = 4'b0100;
                3:    st = 4'b0010;
                4:    st = 4'b0001;
                5:    st = 4'($urandom);
                default: st = 4'b0000;
            endcase
            issue(st[3], st[2], st[1], st[0], 11'($urandom), gir, gpc);
        end

        // Asynchronous reset while an instruction is pending
        wait_valid(ok);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ir_valid), 32'd0);
        chk("arst_pc", 32'(pc_q), 32'd0);
        chk("arst_ovf", 32'(stack_ovf), 32'd0);
        chk("arst_unf", 32'(stack_unf), 32'd0);
        @(negedge clk);
        model_reset();
        release_and_check_first();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 11'h0, gir, gpc);
        chk("post_rst_ret_empty", 32'(gpc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
